// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (difference = a - b), one bit per clock, LSB first.
// Start accepted in IDLE/DONE; results land WIDTH edges later with a one-cycle done pulse; start during SHIFT is ignored.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrowout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             br_next;

    always_comb begin
        d_bit   = a_sr[0] ^ b_sr[0] ^ br;
        br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            difference <= '0;
            borrowout  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {d_bit, res_sr[WIDTH-1:1]};
                    br     <= br_next;
                    if (cnt == LAST) begin
                        // On this last bit the operand LSBs are the original sign bits.
                        difference <= {d_bit, res_sr[WIDTH-1:1]};
                        borrowout  <= br_next;
                        overflow   <= (a_sr[0] != b_sr[0]) && (d_bit != a_sr[0]);
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed table-driven bench for serial_subtractor (WIDTH=4) plus handshake and reset sequences.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [3:0] difference;
    logic       borrowout;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .difference (difference),
        .borrowout  (borrowout),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] va;
        logic [3:0] vb;
        logic [3:0] exp_d;
        logic       exp_bo;
        logic       exp_ov;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive start with operands now; return #1 after the accepting edge.
    task automatic launch(input logic [3:0] x, input logic [3:0] y);
        start = 1'b1;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 4'($urandom);
        b     = 4'($urandom);
    endtask

    // Wait for done, counting busy samples and verifying outputs hold until completion.
    task automatic wait_done(output int busy_n, output logic held);
        int          cyc;
        logic [5:0]  snap;
        busy_n = 0;
        held   = 1'b1;
        cyc    = 0;
        snap   = {difference, borrowout, overflow};
        while (!done && cyc < 20) begin
            if (busy) busy_n++;
            if ({difference, borrowout, overflow} !== snap) held = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 expected done=1 within 20 cycles");
        end
    endtask

    vec_t vecs[9];
    int   bn;
    logic held;
    int   dcount;
    int   bcount;

    initial begin
        vecs[0] = '{4'b0111, 4'b0011, 4'b0100, 1'b0, 1'b0};
        vecs[1] = '{4'b0011, 4'b0111, 4'b1100, 1'b1, 1'b0};
        vecs[2] = '{4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1};
        vecs[3] = '{4'b0111, 4'b1111, 4'b1000, 1'b1, 1'b1};
        vecs[4] = '{4'b0101, 4'b0101, 4'b0000, 1'b0, 1'b0};
        vecs[5] = '{4'b0000, 4'b0001, 4'b1111, 1'b1, 1'b0};
        vecs[6] = '{4'b1000, 4'b0111, 4'b0001, 1'b0, 1'b1};
        vecs[7] = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0};
        vecs[8] = '{4'b1111, 4'b0000, 4'b1111, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = 4'd0;
        b     = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_outs", {difference, borrowout, overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            launch(vecs[i].va, vecs[i].vb);
            wait_done(bn, held);
            chk($sformatf("v%0d_busy_cycles", i), bn, 4);
            chk($sformatf("v%0d_hold", i), held, 1);
            chk($sformatf("v%0d_diff", i), difference, vecs[i].exp_d);
            chk($sformatf("v%0d_borrow", i), borrowout, vecs[i].exp_bo);
            chk($sformatf("v%0d_ovf", i), overflow, vecs[i].exp_ov);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), done, 0);
            chk($sformatf("v%0d_idle_busy", i), busy, 0);
        end

        // Start re-pulsed during SHIFT must be ignored.
        @(negedge clk);
        launch(4'b0101, 4'b0101);
        @(negedge clk);
        start = 1'b1;
        a     = 4'b1111;
        b     = 4'b0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(bn, held);
        chk("ign_diff", {difference, borrowout, overflow}, {4'b0000, 1'b0, 1'b0});
        dcount = 0;
        bcount = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
            if (busy) bcount++;
        end
        chk("ign_no_second_done", dcount, 0);
        chk("ign_no_second_busy", bcount, 0);

        // Back-to-back: start held through the DONE cycle.
        @(negedge clk);
        launch(4'b0101, 4'b0101);
        wait_done(bn, held);
        chk("b2b_first_diff", difference, 4'b0000);
        launch(4'b0010, 4'b0001);
        chk("b2b_busy_now", busy, 1);
        chk("b2b_done_low", done, 0);
        chk("b2b_old_held", difference, 4'b0000);
        wait_done(bn, held);
        chk("b2b_busy_cycles", bn, 4);
        chk("b2b_hold", held, 1);
        chk("b2b_result", {difference, borrowout, overflow}, {4'b0001, 1'b0, 1'b0});

        // Reset mid-SHIFT aborts the operation.
        @(negedge clk);
        launch(4'b0110, 4'b0001);
        wait_done(bn, held);
        chk("pre_rst_diff", difference, 4'b0101);
        @(negedge clk);
        launch(4'b0001, 4'b0010);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_outs", {difference, borrowout, overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        bcount = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
            if (busy) bcount++;
        end
        chk("post_rst_no_done", dcount, 0);
        chk("post_rst_no_busy", bcount, 0);
        chk("post_rst_outs", {difference, borrowout, overflow}, 0);
        @(negedge clk);
        launch(4'b0001, 4'b0010);
        wait_done(bn, held);
        chk("fresh_busy_cycles", bn, 4);
        chk("fresh_result", {difference, borrowout, overflow}, {4'b1111, 1'b1, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
